screen_sched: RTL

SCREEN_SCHED -- requirements
Module: screen_sched

---
 rtl/pong_pkg.sv | 72 +++++++
 rtl/btn_debounce.sv | 44 ++++
 rtl/screen_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the screen scheduler: screen and request codes,
// menu hit-box bounds and the colour palette.
package pong_pkg;

    typedef enum logic [1:0] {
        SCR_MENU    = 2'd0,
        SCR_GAME    = 2'd1,
        SCR_CREDITS = 2'd2
    } screen_t;

    typedef enum logic [2:0] {
        REQ_NONE  = 3'd0,
        REQ_START = 3'd1,
        REQ_DIFF  = 3'd2,
        REQ_COLOR = 3'd3,
        REQ_CRED  = 3'd4,
        REQ_BACK  = 3'd5
    } req_t;

    // Horizontal extent shared by every menu button.
    localparam logic [11:0] BTN_X_MIN   = 12'd362;
    localparam logic [11:0] BTN_X_MAX   = 12'd674;

    // Vertical bands, one per menu button.
    localparam logic [9:0]  START_Y_MIN = 10'd46;
    localparam logic [9:0]  START_Y_MAX = 10'd146;
    localparam logic [9:0]  DIFF_Y_MIN  = 10'd238;
    localparam logic [9:0]  DIFF_Y_MAX  = 10'd338;
    localparam logic [9:0]  COLOR_Y_MIN = 10'd430;
    localparam logic [9:0]  COLOR_Y_MAX = 10'd530;
    localparam logic [9:0]  CRED_Y_MIN  = 10'd622;
    localparam logic [9:0]  CRED_Y_MAX  = 10'd722;

    // Highest legal palette index; stepping past it wraps to zero.
    localparam logic [2:0]  COLOR_LAST  = 3'd6;

    // Palette lookup: returns {color1, color2}; unknown indices fall back to entry 0.
    function automatic logic [23:0] palette_lookup(input logic [2:0] idx);
        logic [23:0] pair;
        case (idx)
            3'd0:    pair = {12'h000, 12'hFFF};
            3'd1:    pair = {12'h099, 12'hF66};
            3'd2:    pair = {12'h909, 12'h6F6};
            3'd3:    pair = {12'h990, 12'h66F};
            3'd4:    pair = {12'h339, 12'hFF6};
            3'd5:    pair = {12'h933, 12'h6FF};
            3'd6:    pair = {12'h393, 12'hF6F};
            default: pair = {12'h000, 12'hFFF};
        endcase
        return pair;
    endfunction

    // Maps a mouse position to the menu button under it (bounds inclusive).
    function automatic req_t region_decode(input logic [11:0] x, input logic [9:0] y);
        req_t r;
        if ((x < BTN_X_MIN) || (x > BTN_X_MAX)) begin
            r = REQ_NONE;
        end else if ((y >= START_Y_MIN) && (y <= START_Y_MAX)) begin
            r = REQ_START;
        end else if ((y >= DIFF_Y_MIN) && (y <= DIFF_Y_MAX)) begin
            r = REQ_DIFF;
        end else if ((y >= COLOR_Y_MIN) && (y <= COLOR_Y_MAX)) begin
            r = REQ_COLOR;
        end else if ((y >= CRED_Y_MIN) && (y <= CRED_Y_MAX)) begin
            r = REQ_CRED;
        end else begin
            r = REQ_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: emits a single one-cycle press once the button has
// been held high for DEBOUNCE_CYCLES consecutive cycles, then waits for the
// button to drop before it can fire again.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          fired_r;
    logic          press_r;

    // Count consecutive high cycles; any low cycle clears and re-arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            fired_r <= 1'b0;
            press_r <= 1'b0;
        end else if (!button) begin
            cnt_r   <= '0;
            fired_r <= 1'b0;
            press_r <= 1'b0;
        end else if (fired_r) begin
            press_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            fired_r <= 1'b1;
            press_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
            press_r <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/screen_sched.sv
// Screen scheduler: turns menu clicks and the "back" push-button into
// requests, holds one pending request and applies it at the next frame
// boundary so screen/difficulty/palette only change between frames.
module screen_sched
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [9:0]  ypos_one,
    input  logic        button,
    input  logic        vblnk_in,
    output logic [1:0]  screen,
    output logic        start,
    output logic        difficulty,
    output logic [2:0]  color_state,
    output logic [11:0] color1,
    output logic [11:0] color2
);

    logic        mouse_prev_r;
    logic        vblnk_prev_r;
    logic        press_s;
    logic        click_s;
    logic        frame_s;
    req_t        hit_req_s;
    logic        event_valid_s;
    req_t        event_req_s;
    logic        pend_valid_r;
    req_t        pend_req_r;
    logic        apply_s;
    screen_t     screen_r;
    screen_t     screen_nxt_s;
    logic        start_r;
    logic        diff_r;
    logic        diff_nxt_s;
    logic [2:0]  color_r;
    logic [2:0]  color_nxt_s;
    logic [11:0] color1_r;
    logic [11:0] color2_r;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .press  (press_s)
    );

    // Edge history for click and frame-boundary detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            mouse_prev_r <= 1'b0;
            vblnk_prev_r <= 1'b0;
        end else begin
            mouse_prev_r <= mouse_left;
            vblnk_prev_r <= vblnk_in;
        end
    end

    assign click_s = mouse_left & ~mouse_prev_r;
    assign frame_s = vblnk_in & ~vblnk_prev_r;

    // Event arbitration: the press wins, but each event is only legal on its own screens.
    always_comb begin
        hit_req_s     = region_decode(xpos, ypos_one);
        event_valid_s = 1'b0;
        event_req_s   = REQ_NONE;
        if (press_s && ((screen_r == SCR_GAME) || (screen_r == SCR_CREDITS))) begin
            event_valid_s = 1'b1;
            event_req_s   = REQ_BACK;
        end else if (click_s && (screen_r == SCR_MENU) && (hit_req_s != REQ_NONE)) begin
            event_valid_s = 1'b1;
            event_req_s   = hit_req_s;
        end else begin
            event_valid_s = 1'b0;
            event_req_s   = REQ_NONE;
        end
    end

    assign apply_s = frame_s & pend_valid_r;

    // One-entry request slot: drained at a frame boundary, otherwise loaded when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_r <= 1'b0;
            pend_req_r   <= REQ_NONE;
        end else if (apply_s) begin
            pend_valid_r <= 1'b0;
            pend_req_r   <= REQ_NONE;
        end else if (event_valid_s && !pend_valid_r) begin
            pend_valid_r <= 1'b1;
            pend_req_r   <= event_req_s;
        end else begin
            pend_valid_r <= pend_valid_r;
            pend_req_r   <= pend_req_r;
        end
    end

    // Screen next-state: transitions only when the pending request is applied.
    always_comb begin
        screen_nxt_s = SCR_MENU;
        case (screen_r)
            SCR_MENU: begin
                if (apply_s && (pend_req_r == REQ_START)) begin
                    screen_nxt_s = SCR_GAME;
                end else if (apply_s && (pend_req_r == REQ_CRED)) begin
                    screen_nxt_s = SCR_CREDITS;
                end else begin
                    screen_nxt_s = SCR_MENU;
                end
            end
            SCR_GAME, SCR_CREDITS: begin
                if (apply_s && (pend_req_r == REQ_BACK)) begin
                    screen_nxt_s = SCR_MENU;
                end else begin
                    screen_nxt_s = screen_r;
                end
            end
            default: screen_nxt_s = SCR_MENU;
        endcase
    end

    // Difficulty and palette index next-state, independent of the screen.
    always_comb begin
        diff_nxt_s  = diff_r;
        color_nxt_s = color_r;
        if (apply_s && (pend_req_r == REQ_DIFF)) begin
            diff_nxt_s = ~diff_r;
        end else begin
            diff_nxt_s = diff_r;
        end
        if (apply_s && (pend_req_r == REQ_COLOR)) begin
            color_nxt_s = (color_r >= COLOR_LAST) ? 3'd0 : (color_r + 3'd1);
        end else begin
            color_nxt_s = color_r;
        end
    end

    // State register; start tracks the screen on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            screen_r <= SCR_MENU;
            start_r  <= 1'b0;
            diff_r   <= 1'b0;
            color_r  <= 3'd0;
        end else begin
            screen_r <= screen_nxt_s;
            start_r  <= (screen_nxt_s == SCR_GAME);
            diff_r   <= diff_nxt_s;
            color_r  <= color_nxt_s;
        end
    end

    // Palette colours follow the registered index one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            color1_r <= 12'h000;
            color2_r <= 12'hFFF;
        end else begin
            {color1_r, color2_r} <= palette_lookup(color_r);
        end
    end

    assign screen      = screen_r;
    assign start       = start_r;
    assign difficulty  = diff_r;
    assign color_state = color_r;
    assign color1      = color1_r;
    assign color2      = color2_r;

endmodule
